// File: rtl/namuru_pkg.sv
// Shared constants and sample payload type for the namuru front-end slice.
package namuru_pkg;

   localparam int unsigned SIGN_W        = 1;
   localparam int unsigned MAG_W         = 1;
   localparam int unsigned WIN_BITS_DEF  = 14;
   localparam int unsigned STUCK_LEN_DEF = 64;
   localparam int unsigned RUN_W         = 16;

   // One conditioned 2-bit front-end sample.
   typedef struct packed {
      logic [SIGN_W-1:0] sign;
      logic [MAG_W-1:0]  mag;
   } fe_sample_t;

endpackage : namuru_pkg

// File: rtl/namuru_fe_stats.sv
// Per-window magnitude / sign-balance accumulation with snapshot on window end.
module namuru_fe_stats
   import namuru_pkg::*;
#(
   parameter int unsigned WIN_BITS = WIN_BITS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                clear,
   input  fe_sample_t          smp,
   output logic [WIN_BITS:0]   mag_count,
   output logic [WIN_BITS:0]   pos_count,
   output logic                stat_valid
);

   localparam int unsigned ACC_W = WIN_BITS + 1;
   localparam logic [WIN_BITS-1:0] WIN_LAST = '1;

   logic [WIN_BITS-1:0] win_cnt_q, win_cnt_d;
   logic [ACC_W-1:0]    mag_acc_q, mag_acc_d;
   logic [ACC_W-1:0]    pos_acc_q, pos_acc_d;
   logic [ACC_W-1:0]    mag_count_q, mag_count_d;
   logic [ACC_W-1:0]    pos_count_q, pos_count_d;
   logic                stat_valid_q, stat_valid_d;
   logic [ACC_W-1:0]    mag_sum, pos_sum;

   // Next-state: clear wins over a coincident window end; en=0 holds everything.
   always_comb begin
      win_cnt_d    = win_cnt_q;
      mag_acc_d    = mag_acc_q;
      pos_acc_d    = pos_acc_q;
      mag_count_d  = mag_count_q;
      pos_count_d  = pos_count_q;
      stat_valid_d = 1'b0;
      mag_sum      = mag_acc_q + ACC_W'(smp.mag);
      pos_sum      = pos_acc_q + ACC_W'(smp.sign);
      if (clear) begin
         win_cnt_d = '0;
         mag_acc_d = '0;
         pos_acc_d = '0;
      end else if (en) begin
         win_cnt_d = win_cnt_q + WIN_BITS'(1);
         if (win_cnt_q == WIN_LAST) begin
            mag_count_d  = mag_sum;
            pos_count_d  = pos_sum;
            stat_valid_d = 1'b1;
            mag_acc_d    = '0;
            pos_acc_d    = '0;
         end else begin
            mag_acc_d = mag_sum;
            pos_acc_d = pos_sum;
         end
      end
   end

   // State and snapshot registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt_q    <= '0;
         mag_acc_q    <= '0;
         pos_acc_q    <= '0;
         mag_count_q  <= '0;
         pos_count_q  <= '0;
         stat_valid_q <= 1'b0;
      end else begin
         win_cnt_q    <= win_cnt_d;
         mag_acc_q    <= mag_acc_d;
         pos_acc_q    <= pos_acc_d;
         mag_count_q  <= mag_count_d;
         pos_count_q  <= pos_count_d;
         stat_valid_q <= stat_valid_d;
      end
   end

   assign mag_count  = mag_count_q;
   assign pos_count  = pos_count_q;
   assign stat_valid = stat_valid_q;

endmodule : namuru_fe_stats

// File: rtl/namuru_frontend.sv
// GPS front-end conditioning: 2-flop input stage, window statistics and an
// optional stuck-sign detector built when NAMURU_FE_STUCK_EN is defined.
module namuru_frontend
   import namuru_pkg::*;
#(
   parameter int unsigned WIN_BITS  = WIN_BITS_DEF,
   parameter int unsigned STUCK_LEN = STUCK_LEN_DEF
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                gps_rec_sign,
   input  logic                gps_rec_mag,
   input  logic                en,
   input  logic                clear,
   output logic                sample_sign,
   output logic                sample_mag,
   output logic [WIN_BITS:0]   mag_count,
   output logic [WIN_BITS:0]   pos_count,
   output logic                stat_valid,
   output logic                stuck
);

   if ((STUCK_LEN < 1) || (STUCK_LEN > 65535)) begin : g_bad_stuck_len
      $error("namuru_frontend: STUCK_LEN out of range 1..65535");
   end

   fe_sample_t s1_q, s1_d, s2_q, s2_d;

   // Input stage: two flops, always running regardless of en/clear.
   always_comb begin
      s1_d.sign = gps_rec_sign;
      s1_d.mag  = gps_rec_mag;
      s2_d      = s1_q;
   end

   // Input synchroniser registers.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign sample_sign = s2_q.sign;
   assign sample_mag  = s2_q.mag;

   namuru_fe_stats #(
      .WIN_BITS (WIN_BITS)
   ) u_stats (
      .clk        (sys_clk),
      .rst_n      (sys_rst),
      .en         (en),
      .clear      (clear),
      .smp        (s2_q),
      .mag_count  (mag_count),
      .pos_count  (pos_count),
      .stat_valid (stat_valid)
   );

`ifdef NAMURU_FE_STUCK_EN
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUCK_LEN);

   logic             prev_sign_q, prev_sign_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             stuck_q, stuck_d;

   // Run length of identical s2 sign samples, saturating at STUCK_LEN.
   always_comb begin
      prev_sign_d = s2_q.sign;
      run_d       = run_q;
      if (s2_q.sign != prev_sign_q) begin
         run_d = '0;
      end else if (run_q != RUN_MAX) begin
         run_d = run_q + RUN_W'(1);
      end
      stuck_d = (run_d == RUN_MAX);
   end

   // Stuck detector registers.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         prev_sign_q <= 1'b0;
         run_q       <= '0;
         stuck_q     <= 1'b0;
      end else begin
         prev_sign_q <= prev_sign_d;
         run_q       <= run_d;
         stuck_q     <= stuck_d;
      end
   end

   assign stuck = stuck_q;
`else
   assign stuck = 1'b0;
`endif

endmodule : namuru_frontend

// File: tb/tb_namuru_frontend.sv
// Directed self-checking bench for namuru_frontend (WIN_BITS=4, STUCK_LEN=8).
module tb_namuru_frontend;

   localparam int unsigned WB = 4;
   localparam int unsigned SL = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          gps_rec_sign = 1'b0;
   logic          gps_rec_mag = 1'b0;
   logic          en = 1'b0;
   logic          clear = 1'b0;
   logic          sample_sign, sample_mag, stat_valid, stuck;
   logic [WB:0]   mag_count, pos_count;
   logic          sign_alt = 1'b0;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   namuru_frontend #(.WIN_BITS(WB), .STUCK_LEN(SL)) dut (
      .sys_clk      (clk),
      .sys_rst      (rst_n),
      .gps_rec_sign (gps_rec_sign),
      .gps_rec_mag  (gps_rec_mag),
      .en           (en),
      .clear        (clear),
      .sample_sign  (sample_sign),
      .sample_mag   (sample_mag),
      .mag_count    (mag_count),
      .pos_count    (pos_count),
      .stat_valid   (stat_valid),
      .stuck        (stuck)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (sign_alt) gps_rec_sign = ~gps_rec_sign;
   endtask

   task automatic prime(input logic mag, input logic sign, input logic alt);
      gps_rec_mag  = mag;
      gps_rec_sign = sign;
      sign_alt     = alt;
      en           = 1'b1;
      clear        = 1'b1;
      repeat (3) tick();
      clear        = 1'b0;
   endtask

   task automatic test_reset();
      logic [13:0] outs;
      rst_n    = 1'b0;
      sign_alt = 1'b1;
      en       = 1'b1;
      for (int i = 0; i < 4; i++) begin
         gps_rec_mag = ~gps_rec_mag;
         tick();
         outs = {sample_sign, sample_mag, mag_count, pos_count, stat_valid, stuck};
         chk_cnt++;
         if (outs !== 14'h0) $display("FAIL reset_outs: got %h expected 0", outs);
         else pass_cnt++;
      end
      sign_alt     = 1'b0;
      en           = 1'b0;
      gps_rec_sign = 1'b1;
      gps_rec_mag  = 1'b1;
      rst_n        = 1'b1;
      tick();
      chk_cnt++;
      if ({sample_sign, sample_mag} !== 2'b00)
         $display("FAIL latency_1: got %b expected 00", {sample_sign, sample_mag});
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({sample_sign, sample_mag} !== 2'b11)
         $display("FAIL latency_2: got %b expected 11", {sample_sign, sample_mag});
      else pass_cnt++;
   endtask

   task automatic test_window_alt();
      prime(1'b1, 1'b1, 1'b1);
      for (int e = 1; e <= 32; e++) begin
         tick();
         chk_cnt++;
         if (stat_valid !== (e % 16 == 0))
            $display("FAIL alt_valid e=%0d: got %b expected %b", e, stat_valid, (e % 16 == 0));
         else pass_cnt++;
         if (e % 16 == 0) begin
            chk_cnt++;
            if (mag_count !== 5'd16 || pos_count !== 5'd8)
               $display("FAIL alt_counts e=%0d: got %0d/%0d expected 16/8", e, mag_count, pos_count);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_mag_zero();
      prime(1'b0, 1'b1, 1'b0);
      for (int e = 1; e <= 16; e++) begin
         tick();
         chk_cnt++;
         if (stat_valid !== (e == 16))
            $display("FAIL mz_valid e=%0d: got %b expected %b", e, stat_valid, (e == 16));
         else pass_cnt++;
      end
      chk_cnt++;
      if (mag_count !== 5'd0 || pos_count !== 5'd16)
         $display("FAIL mz_counts: got %0d/%0d expected 0/16", mag_count, pos_count);
      else pass_cnt++;
   endtask

   task automatic test_en_gap();
      prime(1'b1, 1'b0, 1'b0);
      for (int e = 1; e <= 21; e++) begin
         tick();
         chk_cnt++;
         if (stat_valid !== (e == 21))
            $display("FAIL gap_valid e=%0d: got %b expected %b", e, stat_valid, (e == 21));
         else pass_cnt++;
         if (e == 8)  en = 1'b0;
         if (e == 13) en = 1'b1;
      end
      chk_cnt++;
      if (mag_count !== 5'd16 || pos_count !== 5'd0)
         $display("FAIL gap_counts: got %0d/%0d expected 16/0", mag_count, pos_count);
      else pass_cnt++;
   endtask

   task automatic test_clear_on_end();
      prime(1'b1, 1'b1, 1'b0);
      for (int e = 1; e <= 32; e++) begin
         tick();
         chk_cnt++;
         if (stat_valid !== (e == 32))
            $display("FAIL clr_valid e=%0d: got %b expected %b", e, stat_valid, (e == 32));
         else pass_cnt++;
         if (e == 16) begin
            chk_cnt++;
            if (mag_count !== 5'd16 || pos_count !== 5'd0)
               $display("FAIL clr_keep: got %0d/%0d expected 16/0", mag_count, pos_count);
            else pass_cnt++;
         end
         if (e == 15) clear = 1'b1;
         if (e == 16) clear = 1'b0;
      end
      chk_cnt++;
      if (mag_count !== 5'd16 || pos_count !== 5'd16)
         $display("FAIL clr_next: got %0d/%0d expected 16/16", mag_count, pos_count);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_window();
      gps_rec_mag  = 1'b1;
      gps_rec_sign = 1'b1;
      sign_alt     = 1'b0;
      en           = 1'b1;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({mag_count, pos_count, stat_valid} !== 11'h0)
         $display("FAIL rst_mid_clear: got %h expected 0", {mag_count, pos_count, stat_valid});
      else pass_cnt++;
      tick();
      rst_n = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         tick();
         chk_cnt++;
         if (stat_valid !== (e == 16))
            $display("FAIL rst_mid_valid e=%0d: got %b expected %b", e, stat_valid, (e == 16));
         else pass_cnt++;
      end
      chk_cnt++;
      if (mag_count !== 5'd14 || pos_count !== 5'd14)
         $display("FAIL rst_mid_counts: got %0d/%0d expected 14/14", mag_count, pos_count);
      else pass_cnt++;
   endtask

   task automatic test_stuck();
      logic exp;
      en           = 1'b0;
      sign_alt     = 1'b0;
      gps_rec_sign = 1'b0;
      rst_n        = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         tick();
`ifdef NAMURU_FE_STUCK_EN
         exp = (e >= 8) && (e <= 12);
`else
         exp = 1'b0;
`endif
         chk_cnt++;
         if (stuck !== exp)
            $display("FAIL stuck e=%0d: got %b expected %b", e, stuck, exp);
         else pass_cnt++;
         if (e == 10) gps_rec_sign = 1'b1;
      end
   endtask

   initial begin
      test_reset();
      test_window_alt();
      test_mag_zero();
      test_en_gap();
      test_clear_on_end();
      test_reset_mid_window();
      test_stuck();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule : tb_namuru_frontend
